// File: rtl/xpb_reduce_seq.sv
// Reduction scheduler: issues the NUM_SEG overflow segments of a squaring result one per cycle
// to a shared residue-LUT port and accumulates the returned residues into one partial sum.
module xpb_reduce_seq #(
  parameter int NUM_SEG = 8,
  parameter int SEG_W   = 5,
  parameter int DATA_W  = 1024,
  parameter int LUT_LAT = 1,
  localparam int SEL_W  = $clog2(NUM_SEG),
  localparam int ACC_W  = DATA_W + $clog2(NUM_SEG)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NUM_SEG*SEG_W-1:0] upper_in,
  input  logic                     flush,
  output logic                     ready,
  output logic [SEL_W-1:0]         lut_sel,
  output logic [SEG_W-1:0]         lut_addr,
  input  logic [DATA_W-1:0]        lut_data,
  output logic [ACC_W-1:0]         sum_out,
  output logic                     sum_valid
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  localparam int               TAG_W    = (LUT_LAT > 0) ? LUT_LAT : 1;
  localparam logic [TAG_W-1:0] TAG_LOW  = {TAG_W{1'b1}} >> 1;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_SEG - 1);

  state_e                   state_q, state_d;
  logic [SEL_W-1:0]         sel_q, sel_d;
  logic [SEG_W-1:0]         addr_q, addr_d;
  logic [NUM_SEG*SEG_W-1:0] seg_q, seg_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [ACC_W-1:0]         sum_q, sum_d;
  logic                     sum_valid_q, sum_valid_d;
  logic [TAG_W-1:0]         tag_q, tag_d;

  logic issue_v;
  logic acc_en;
  logic last_ret;

  // lut_sel doubles as the issue counter k: it is only non-zero while issuing.
  assign issue_v  = (state_q == ISSUE);
  assign acc_en   = (LUT_LAT == 0) ? issue_v : tag_q[TAG_W-1];
  assign last_ret = tag_q[TAG_W-1] && ((tag_q & TAG_LOW) == '0);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state_q;
    sel_d       = '0;
    addr_d      = '0;
    seg_d       = seg_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    sum_valid_d = 1'b0;
    tag_d       = (tag_q << 1) | TAG_W'(issue_v);

    if (acc_en) acc_d = acc_q + ACC_W'(lut_data);

    case (state_q)
      IDLE: begin
        if (start) begin
          seg_d   = upper_in;
          acc_d   = '0;
          addr_d  = upper_in[SEG_W-1:0];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (sel_q == LAST_SEL) begin
          state_d = (LUT_LAT == 0) ? DONE : DRAIN;
        end else begin
          sel_d  = sel_q + 1'b1;
          addr_d = seg_q[int'(sel_d)*SEG_W +: SEG_W];
        end
      end
      DRAIN:   if (last_ret) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The final return is folded in on the same edge that publishes the sum.
    if (state_d == DONE) begin
      sum_d       = acc_d;
      sum_valid_d = 1'b1;
    end

    if (flush) begin
      state_d     = IDLE;
      sel_d       = '0;
      addr_d      = '0;
      acc_d       = '0;
      tag_d       = '0;
      sum_d       = sum_q;
      sum_valid_d = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      addr_q      <= '0;
      // NOTE: the wide segment/accumulator registers are reset too, so no stale data survives a reset.
      seg_q       <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      seg_q       <= seg_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      tag_q       <= tag_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign lut_sel   = sel_q;
  assign lut_addr  = addr_q;
  assign sum_out   = sum_q;
  assign sum_valid = sum_valid_q;

endmodule

// File: tb/tb_xpb_reduce_seq.sv
// Directed bench for xpb_reduce_seq: LUT_LAT=1 main instance plus LUT_LAT=0 and LUT_LAT=3 builds
// sharing the same stimulus, each with its own behavioural residue LUT.
module tb_xpb_reduce_seq;

  localparam int NUM_SEG = 8;
  localparam int SEG_W   = 5;
  localparam int DATA_W  = 1024;
  localparam int SEL_W   = 3;
  localparam int ACC_W   = 1027;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic flush = 1'b0;
  logic lut_ones = 1'b0;
  logic [NUM_SEG*SEG_W-1:0] upper_in = '0;

  logic              ready0, ready1, ready3;
  logic [SEL_W-1:0]  sel0, sel1, sel3;
  logic [SEG_W-1:0]  addr0, addr1, addr3;
  logic [DATA_W-1:0] lut_data0, lut_data1, lut_data3, p3a, p3b;
  logic [ACC_W-1:0]  sum_out0, sum_out1, sum_out3;
  logic              sum_valid0, sum_valid1, sum_valid3;

  int checks = 0;
  int failures = 0;

  int vc0, vc1, vc3, np0, np1, np3;
  logic [ACC_W-1:0] s0, s1, s3;
  logic [SEL_W-1:0] sel_tr [0:63];
  logic [SEG_W-1:0] addr_tr [0:63];
  logic             rdy_tr [0:63];

  always #5 clk = ~clk;

  xpb_reduce_seq #(.NUM_SEG(NUM_SEG), .SEG_W(SEG_W), .DATA_W(DATA_W), .LUT_LAT(0)) u_dut_lat0 (
    .clk(clk), .rst_n(rst_n), .start(start), .upper_in(upper_in), .flush(flush),
    .ready(ready0), .lut_sel(sel0), .lut_addr(addr0), .lut_data(lut_data0),
    .sum_out(sum_out0), .sum_valid(sum_valid0));

  xpb_reduce_seq #(.NUM_SEG(NUM_SEG), .SEG_W(SEG_W), .DATA_W(DATA_W), .LUT_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .upper_in(upper_in), .flush(flush),
    .ready(ready1), .lut_sel(sel1), .lut_addr(addr1), .lut_data(lut_data1),
    .sum_out(sum_out1), .sum_valid(sum_valid1));

  xpb_reduce_seq #(.NUM_SEG(NUM_SEG), .SEG_W(SEG_W), .DATA_W(DATA_W), .LUT_LAT(3)) u_dut_lat3 (
    .clk(clk), .rst_n(rst_n), .start(start), .upper_in(upper_in), .flush(flush),
    .ready(ready3), .lut_sel(sel3), .lut_addr(addr3), .lut_data(lut_data3),
    .sum_out(sum_out3), .sum_valid(sum_valid3));

  function automatic logic [DATA_W-1:0] lut_f(input logic ones, input logic [SEL_W-1:0] s,
                                              input logic [SEG_W-1:0] a);
    if (ones) return '1;
    return DATA_W'({s, a});
  endfunction

  assign lut_data0 = lut_f(lut_ones, sel0, addr0);
  always @(posedge clk) lut_data1 <= lut_f(lut_ones, sel1, addr1);
  always @(posedge clk) begin
    p3a       <= lut_f(lut_ones, sel3, addr3);
    p3b       <= p3a;
    lut_data3 <= p3b;
  end

  task automatic set_pattern();
    for (int k = 0; k < NUM_SEG; k++) upper_in[k*SEG_W +: SEG_W] = SEG_W'(k + 1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    checks++;
    if (ready1 !== 1'b1) begin
      failures++;
      $display("FAIL start_ready: ready=%b expected 1", ready1);
    end
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (ready0 && ready1 && ready3) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL idle_timeout: ready=%b%b%b expected 111", ready0, ready1, ready3);
    end
  endtask

  // Samples cycles 1..max_c after a start edge; cycle c is the one following that edge by c-1 edges.
  task automatic watch(input int max_c);
    vc0 = 0; vc1 = 0; vc3 = 0; np0 = 0; np1 = 0; np3 = 0;
    s0 = '0; s1 = '0; s3 = '0;
    for (int c = 1; c <= max_c; c++) begin
      @(negedge clk);
      sel_tr[c]  = sel1;
      addr_tr[c] = addr1;
      rdy_tr[c]  = ready1;
      if (sum_valid0) begin if (np0 == 0) begin vc0 = c; s0 = sum_out0; end np0++; end
      if (sum_valid1) begin if (np1 == 0) begin vc1 = c; s1 = sum_out1; end np1++; end
      if (sum_valid3) begin if (np3 == 0) begin vc3 = c; s3 = sum_out3; end np3++; end
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [ACC_W-1:0] exp_sum);
    checks++;
    if (ready1 !== 1'b1 || sel1 !== '0 || addr1 !== '0 || sum_valid1 !== 1'b0) begin
      failures++;
      $display("FAIL %s_ctrl: ready=%b sel=%0d addr=%0d valid=%b expected 1 0 0 0",
               tag, ready1, sel1, addr1, sum_valid1);
    end
    checks++;
    if (sum_out1 !== exp_sum) begin
      failures++;
      $display("FAIL %s_sum: got %0d expected %0d", tag, sum_out1[31:0], exp_sum[31:0]);
    end
  endtask

  task automatic test_reset();
    #2 check_idle_outputs("reset_async", '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_release", '0);
  endtask

  task automatic test_basic();
    lut_ones = 1'b0;
    set_pattern();
    pulse_start();
    watch(14);
    checks++;
    if (vc1 !== 10 || np1 !== 1) begin
      failures++;
      $display("FAIL basic_latency: cycle=%0d pulses=%0d expected 10 1", vc1, np1);
    end
    checks++;
    if (s1 !== ACC_W'(932)) begin
      failures++;
      $display("FAIL basic_sum: got %0d expected 932", s1[31:0]);
    end
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (sel_tr[c] !== SEL_W'(c - 1) || addr_tr[c] !== SEG_W'(c)) begin
        failures++;
        $display("FAIL basic_issue_c%0d: sel=%0d addr=%0d expected %0d %0d",
                 c, sel_tr[c], addr_tr[c], c - 1, c);
      end
    end
    checks++;
    if (sel_tr[9] !== '0 || addr_tr[9] !== '0) begin
      failures++;
      $display("FAIL basic_post_issue: sel=%0d addr=%0d expected 0 0", sel_tr[9], addr_tr[9]);
    end
    checks++;
    if (rdy_tr[10] !== 1'b0 || rdy_tr[11] !== 1'b1) begin
      failures++;
      $display("FAIL basic_ready: c10=%b c11=%b expected 0 1", rdy_tr[10], rdy_tr[11]);
    end
  endtask

  task automatic test_all_ones();
    logic [ACC_W-1:0] exp_ones;
    exp_ones = {{(ACC_W-3){1'b1}}, 3'b000};
    wait_idle();
    lut_ones = 1'b1;
    upper_in = '1;
    pulse_start();
    watch(14);
    checks++;
    if (vc1 !== 10 || s1 !== exp_ones) begin
      failures++;
      $display("FAIL all_ones: cycle=%0d top=%h low=%h expected 10 top=%h low=%h",
               vc1, s1[ACC_W-1 -: 32], s1[31:0], exp_ones[ACC_W-1 -: 32], exp_ones[31:0]);
    end
    lut_ones = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc_cnt = 0;
    int pulses = 0;
    int first_acc = -1;
    int second_acc = -1;
    wait_idle();
    set_pattern();
    start = 1'b1;
    for (int n = 0; n < 44; n++) begin
      if (n > 0) @(negedge clk);
      if (ready1 && start) begin
        if (acc_cnt == 0) first_acc = n;
        else if (acc_cnt == 1) second_acc = n;
        acc_cnt++;
      end
      if (sum_valid1) begin
        pulses++;
        checks++;
        if (sum_out1 !== ACC_W'(932)) begin
          failures++;
          $display("FAIL b2b_sum_%0d: got %0d expected 932", pulses, sum_out1[31:0]);
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (acc_cnt !== 4 || pulses !== 4) begin
      failures++;
      $display("FAIL b2b_counts: accepts=%0d pulses=%0d expected 4 4", acc_cnt, pulses);
    end
    checks++;
    if (second_acc - first_acc !== 11) begin
      failures++;
      $display("FAIL b2b_interval: got %0d expected 11", second_acc - first_acc);
    end
  endtask

  task automatic test_flush();
    wait_idle();
    set_pattern();
    pulse_start();
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check_idle_outputs("flush", ACC_W'(932));
    upper_in = '0;
    pulse_start();
    watch(14);
    checks++;
    if (np1 !== 1 || vc1 !== 10 || s1 !== ACC_W'(896)) begin
      failures++;
      $display("FAIL flush_restart: pulses=%0d cycle=%0d sum=%0d expected 1 10 896",
               np1, vc1, s1[31:0]);
    end
  endtask

  task automatic test_reset_mid();
    wait_idle();
    set_pattern();
    pulse_start();
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1 check_idle_outputs("reset_mid", '0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    watch(14);
    checks++;
    if (np1 !== 1 || vc1 !== 10 || s1 !== ACC_W'(932)) begin
      failures++;
      $display("FAIL reset_restart: pulses=%0d cycle=%0d sum=%0d expected 1 10 932",
               np1, vc1, s1[31:0]);
    end
  endtask

  task automatic test_latency_builds();
    wait_idle();
    set_pattern();
    pulse_start();
    watch(16);
    checks++;
    if (np0 !== 1 || vc0 !== 9 || s0 !== ACC_W'(932)) begin
      failures++;
      $display("FAIL lat0: pulses=%0d cycle=%0d sum=%0d expected 1 9 932", np0, vc0, s0[31:0]);
    end
    checks++;
    if (np3 !== 1 || vc3 !== 12 || s3 !== ACC_W'(932)) begin
      failures++;
      $display("FAIL lat3: pulses=%0d cycle=%0d sum=%0d expected 1 12 932", np3, vc3, s3[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_ones();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_latency_builds();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
